// File: rtl/countdown_timer_if.sv
// Signal bundle between the game-state FSM (master) and the countdown timer (slave).
interface countdown_timer_if;
    logic       game_start;
    logic       cnt_enable;
    logic [3:0] time_remain;
    logic       sec_tick;
    logic       expired;
    logic       low_time;
    logic       blink;

    modport master (
        output game_start, cnt_enable,
        input  time_remain, sec_tick, expired, low_time, blink
    );

    modport slave (
        input  game_start, cnt_enable,
        output time_remain, sec_tick, expired, low_time, blink
    );
endinterface

// File: rtl/countdown_timer.sv
// Game countdown: divides clk to one-second ticks, counts START_TIME down to zero,
// and flags low time / blink for the display.
module countdown_timer #(
    parameter int CLK_DIV    = 100_000_000,
    parameter int START_TIME = 15,
    parameter int WARN_TIME  = 3
) (
    input  logic                clk,
    input  logic                rst,
    countdown_timer_if.slave    tif
);

    localparam int              PW         = $clog2(CLK_DIV);
    localparam logic [PW-1:0]   PRESC_MAX  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0]   PRESC_HALF = PW'(CLK_DIV / 2);
    localparam logic [3:0]      START_T    = 4'(START_TIME);
    localparam logic [3:0]      WARN_T     = 4'(WARN_TIME);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      time_q, time_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            start_d_q, start_d_d;
    logic            tick_q, tick_d;
    logic            exp_q, exp_d;
    logic            start_re;

    // Floor at zero so a stray decrement can never wrap the display to 15.
    function automatic logic [3:0] sat_dec(input logic [3:0] v);
        return (v == 4'd0) ? 4'd0 : v - 4'd1;
    endfunction

    always_comb begin
        start_re  = tif.game_start & ~start_d_q;
        start_d_d = tif.game_start;
        state_d   = state_q;
        time_d    = time_q;
        presc_d   = presc_q;
        tick_d    = 1'b0;
        exp_d     = 1'b0;

        if (start_re) begin
            state_d = RUN;
            time_d  = START_T;
            presc_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    time_d  = START_T;
                    presc_d = '0;
                end
                RUN: begin
                    // A pause request beats a second boundary landing in the same cycle.
                    if (!tif.cnt_enable) begin
                        state_d = PAUSE;
                    end else if (presc_q == PRESC_MAX) begin
                        presc_d = '0;
                        time_d  = sat_dec(time_q);
                        tick_d  = 1'b1;
                        if (time_q == 4'd1) begin
                            state_d = DONE;
                            exp_d   = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                PAUSE: begin
                    if (tif.cnt_enable) state_d = RUN;
                end
                DONE: begin
                    time_d  = 4'd0;
                    presc_d = '0;
                end
                default: begin
                    state_d = IDLE;
                    time_d  = START_T;
                    presc_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            time_q    <= START_T;
            presc_q   <= '0;
            start_d_q <= 1'b0;
            tick_q    <= 1'b0;
            exp_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            presc_q   <= presc_d;
            start_d_q <= start_d_d;
            tick_q    <= tick_d;
            exp_q     <= exp_d;
        end
    end

    assign tif.time_remain = time_q;
    assign tif.sec_tick    = tick_q;
    assign tif.expired     = exp_q;
    assign tif.low_time    = ((state_q == RUN) || (state_q == PAUSE)) && (time_q <= WARN_T);
    assign tif.blink       = tif.low_time && (presc_q < PRESC_HALF);

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized scoreboard bench for countdown_timer against a seconds/cycles reference model.
module tb_countdown_timer;

    localparam int CLK_DIV    = 4;
    localparam int START_TIME = 5;
    localparam int WARN_TIME  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    countdown_timer_if tif ();

    countdown_timer #(
        .CLK_DIV    (CLK_DIV),
        .START_TIME (START_TIME),
        .WARN_TIME  (WARN_TIME)
    ) dut (
        .clk (clk),
        .rst (rst),
        .tif (tif)
    );

    always #5 clk = ~clk;

    typedef struct {
        int t;
        bit tick;
        bit expd;
        bit low;
        bit blink;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;

    // Reference model: game is either not started, counting, held, or finished.
    bit started, held, finished;
    int secs_left;
    int cycles_into_sec;
    bit prev_start;

    task automatic chk(input string nm, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", nm, cyc_n, act, want);
        end
    endtask

    task automatic model_step(input bit r, input bit g, input bit e, output exp_t x);
        bit tick, expd, active;
        tick = 0;
        expd = 0;
        if (r) begin
            started = 0; held = 0; finished = 0;
            secs_left = START_TIME; cycles_into_sec = 0; prev_start = 0;
        end else begin
            if (g && !prev_start) begin
                started = 1; held = 0; finished = 0;
                secs_left = START_TIME; cycles_into_sec = 0;
            end else if (started && !finished && !held) begin
                if (!e) held = 1;
                else begin
                    cycles_into_sec++;
                    if (cycles_into_sec == CLK_DIV) begin
                        cycles_into_sec = 0;
                        secs_left = secs_left - 1;
                        tick = 1;
                        if (secs_left == 0) begin
                            finished = 1;
                            expd = 1;
                        end
                    end
                end
            end else if (started && !finished && held) begin
                if (e) held = 0;
            end
            prev_start = g;
        end
        active  = started && !finished;
        x.t     = secs_left;
        x.tick  = tick;
        x.expd  = expd;
        x.low   = active && (secs_left <= WARN_TIME);
        x.blink = x.low && (cycles_into_sec < CLK_DIV / 2);
    endtask

    task automatic cyc(input bit r, input bit g, input bit e);
        exp_t x;
        @(negedge clk);
        rst = r;
        tif.game_start = g;
        tif.cnt_enable = e;
        model_step(r, g, e, x);
        q.push_back(x);
    endtask

    // Monitor: compare each registered DUT output set against the queued expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                cyc_n++;
                chk("time_remain", int'(tif.time_remain), x.t);
                chk("sec_tick",    int'(tif.sec_tick),    int'(x.tick));
                chk("expired",     int'(tif.expired),     int'(x.expd));
                chk("low_time",    int'(tif.low_time),    int'(x.low));
                chk("blink",       int'(tif.blink),       int'(x.blink));
            end
        end
    end

    initial begin
        int guard;
        tif.game_start = 1'b0;
        tif.cnt_enable = 1'b0;
        started = 0; held = 0; finished = 0;
        secs_left = START_TIME; cycles_into_sec = 0; prev_start = 0;

        // Reset, then idle with enable wiggling: nothing may change.
        repeat (3) cyc(1, 0, 0);
        repeat (100) cyc(0, 0, 1'($urandom_range(0, 1)));

        // Full countdown to expiry, then hold in the finished state.
        cyc(0, 1, 1);
        repeat (30) cyc(0, 0, 1);

        // Pause after two counted cycles, resume, and check the held partial second.
        cyc(0, 1, 1);
        repeat (2) cyc(0, 0, 1);
        repeat (10) cyc(0, 0, 0);
        repeat (12) cyc(0, 0, 1);

        // Level-held start reloads only once.
        repeat (20) cyc(0, 1, 1);
        repeat (10) cyc(0, 0, 1);

        // Restart exactly when the final wrap is due.
        cyc(0, 1, 1);
        guard = 0;
        while (!(secs_left == 1 && cycles_into_sec == CLK_DIV - 1) && guard < 100) begin
            cyc(0, 0, 1);
            guard++;
        end
        chk("reach_last_wrap", int'(guard < 100), 1);
        cyc(0, 1, 1);
        repeat (12) cyc(0, 0, 1);

        // Reset in the middle of a count.
        repeat (3) cyc(0, 0, 1);
        cyc(1, 0, 1);
        repeat (5) cyc(0, 0, 1);

        // Randomized traffic: frequent, then sparse restarts.
        for (int i = 0; i < 1500; i++)
            cyc(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 15) == 0),
                1'($urandom_range(0, 3) != 0));
        for (int i = 0; i < 1500; i++)
            cyc(1'($urandom_range(0, 499) == 0), 1'($urandom_range(0, 63) == 0),
                1'($urandom_range(0, 7) != 0));

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
